// File: rtl/fuzzy_defuzz.sv
// fuzzy_defuzz: weighted-average (centroid of singletons) defuzzifier.
// One {min,mid,max} membership triple per transaction goes through a
// 3-cycle serial MAC. The result then leaves through one of three paths:
// a zero-sum error path, a shift fast path for a sum of exactly 256, or a
// 20-cycle restoring divider. Only one transaction is in flight at a time.
module fuzzy_defuzz #(
    parameter logic [7:0] S_LO  = 8'd0,
    parameter logic [7:0] S_MID = 8'd128,
    parameter logic [7:0] S_HI  = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] mem_min,
    input  logic [9:0] mem_mid,
    input  logic [9:0] mem_max,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC  = 3'd1,
        CHK  = 3'd2,
        DIV  = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [4:0]  DIV_BITS = 5'd20;
    localparam logic [11:0] DEN_POW2 = 12'd256;

    state_t      state, state_nxt;

    // Membership triple latched at accept; later input changes are ignored.
    logic [9:0]  m_lo, m_mid, m_hi;

    // 3*1023*255 < 2^20 and 3*1023 < 2^12, so neither accumulator can wrap.
    logic [19:0] acc;
    logic [11:0] den;
    logic [1:0]  idx;

    // The divider shifts the dividend out of quo MSB-first while the
    // quotient bits shift in at the LSB end.
    logic [19:0] quo;
    logic [11:0] rem;
    logic [4:0]  cnt;

    // MAC operands for the current idx.
    logic [9:0]  mac_m;
    logic [7:0]  mac_s;
    logic [19:0] mac_prod;

    // Divider single-step signals.
    logic [12:0] div_trial;
    logic        div_ge;
    logic [11:0] div_rem_nxt;
    logic [19:0] div_quo_nxt;
    logic [7:0]  div_sat;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)                            state_nxt = MAC;
            MAC:  if (idx == 2'd2)                         state_nxt = CHK;
            CHK:  if ((den == '0) || (den == DEN_POW2))    state_nxt = OUT;
                  else                                     state_nxt = DIV;
            DIV:  if (cnt == 5'd1)                         state_nxt = OUT;
            OUT:  if (out_ready)                           state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // Select the membership and its singleton for this MAC step.
    always_comb begin
        mac_m = m_lo;
        mac_s = S_LO;
        case (idx)
            2'd1: begin mac_m = m_mid; mac_s = S_MID; end
            2'd2: begin mac_m = m_hi;  mac_s = S_HI;  end
            default: ;
        endcase
    end

    assign mac_prod = {10'd0, mac_m} * {12'd0, mac_s};

    // One restoring-divide step. The remainder always stays below den, so
    // 12 bits hold it. The trial value needs one extra bit for the compare.
    assign div_trial   = {rem, quo[19]};
    assign div_ge      = (div_trial >= {1'b0, den});
    assign div_rem_nxt = div_ge ? (div_trial[11:0] - den) : div_trial[11:0];
    assign div_quo_nxt = {quo[18:0], div_ge};

    // Saturation guard; legal 8-bit singletons never trip it.
    assign div_sat = (|div_quo_nxt[19:8]) ? 8'hFF : div_quo_nxt[7:0];

    // Datapath: capture, MAC, path decision, divide and output hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_lo      <= '0;
            m_mid     <= '0;
            m_hi      <= '0;
            acc       <= '0;
            den       <= '0;
            idx       <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_lo  <= mem_min;
                        m_mid <= mem_mid;
                        m_hi  <= mem_max;
                        acc   <= '0;
                        den   <= '0;
                        idx   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + mac_prod;
                    den <= den + {2'b00, mac_m};
                    idx <= idx + 2'd1;
                end
                CHK: begin
                    if (den == '0) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (den == DEN_POW2) begin
                        // A divide by 256 is a byte shift (truncating).
                        out_data  <= acc[15:8];
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        quo <= acc;
                        rem <= '0;
                        cnt <= DIV_BITS;
                    end
                end
                DIV: begin
                    quo <= div_quo_nxt;
                    rem <= div_rem_nxt;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        out_data  <= div_sat;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    // The data and err registers are not written here, so
                    // they stay stable while the result waits for out_ready.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_defuzz.sv
// Bench for fuzzy_defuzz. It applies a table of directed triples, then
// random triples checked against a reference model, then hand-written
// sequences for backpressure and for a reset during a divide. Expected
// results pass through a scoreboard queue.
module tb_fuzzy_defuzz;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] mem_min = '0;
    logic [9:0] mem_mid = '0;
    logic [9:0] mem_max = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         lat;
    } exp_t;

    typedef struct {
        logic [9:0] mn, md, mx;
        exp_t       ex;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];

    fuzzy_defuzz dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_min   (mem_min),
        .mem_mid   (mem_mid),
        .mem_max   (mem_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: singletons 0/128/255, truncating divide, 255 saturation.
    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        exp_t r;
        int s, ac, q;
        s  = int'(a) + int'(b) + int'(c);
        ac = int'(b) * 128 + int'(c) * 255;
        if (s == 0) begin
            r.d = 8'd0; r.e = 1'b1; r.lat = 5;
        end else if (s == 256) begin
            r.d = 8'((ac >> 8) & 255); r.e = 1'b0; r.lat = 5;
        end else begin
            q = ac / s;
            r.d = (q > 255) ? 8'd255 : 8'(q); r.e = 1'b0; r.lat = 25;
        end
        return r;
    endfunction

    // Offer one triple, measure latency in edges counted from the accept
    // edge (inclusive), compare against the scoreboard head, optionally
    // hold out_ready low for 'hold' cycles, then accept the result.
    task automatic run(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                       input exp_t ex, input string nm, input int hold);
        int   guard;
        int   lat;
        exp_t e;
        logic [7:0] d0;
        @(negedge clk);
        mem_min = a; mem_mid = b; mem_max = c; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_accept_bound"}, longint'(guard < 100), 1);
        @(posedge clk);
        sb.push_back(ex);
        #1;
        in_valid = 1'b0;
        mem_min = 10'($urandom); mem_mid = 10'($urandom); mem_max = 10'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check({nm, "_latency"}, lat, e.lat);
        check({nm, "_data"}, out_data, e.d);
        check({nm, "_err"}, out_err, e.e);
        d0 = out_data;
        if (hold > 0) begin
            // A competing triple must not be taken while the result waits.
            mem_min = 10'd0; mem_mid = 10'd0; mem_max = 10'd256; in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({nm, "_hold_valid"}, out_valid, 1);
                check({nm, "_hold_data"}, out_data, d0);
                check({nm, "_hold_inrdy"}, in_ready, 0);
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({nm, "_drop_valid"}, out_valid, 0);
        check({nm, "_inrdy_back"}, in_ready, 1);
    endtask

    initial begin
        exp_t e;
        logic [9:0] a, b, c;
        bit   seen;

        // Directed table: {min, mid, max} -> {data, err, latency}.
        tbl[0]  = '{10'd256,  10'd0,    10'd0,    '{8'd0,   1'b0, 5}};
        tbl[1]  = '{10'd0,    10'd112,  10'd144,  '{8'd199, 1'b0, 5}};
        tbl[2]  = '{10'd100,  10'd100,  10'd0,    '{8'd64,  1'b0, 25}};
        tbl[3]  = '{10'd0,    10'd0,    10'd0,    '{8'd0,   1'b1, 5}};
        tbl[4]  = '{10'd0,    10'd0,    10'd256,  '{8'd255, 1'b0, 5}};
        tbl[5]  = '{10'd0,    10'd256,  10'd0,    '{8'd128, 1'b0, 5}};
        tbl[6]  = '{10'd1023, 10'd1023, 10'd1023, '{8'd127, 1'b0, 25}};
        tbl[7]  = '{10'd0,    10'd0,    10'd1,    '{8'd255, 1'b0, 25}};
        tbl[8]  = '{10'd0,    10'd1,    10'd0,    '{8'd128, 1'b0, 25}};
        tbl[9]  = '{10'd3,    10'd0,    10'd1,    '{8'd63,  1'b0, 25}};
        tbl[10] = '{10'd0,    10'd1023, 10'd0,    '{8'd128, 1'b0, 25}};
        tbl[11] = '{10'd1,    10'd2,    10'd3,    '{8'd170, 1'b0, 25}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++)
            run(tbl[i].mn, tbl[i].md, tbl[i].mx, tbl[i].ex, $sformatf("tbl%0d", i), 0);

        for (int i = 0; i < 16; i++) begin
            a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
            if (i % 4 == 0) begin a = 10'($urandom_range(0, 256)); b = 10'(256) - a; c = 10'd0; end
            run(a, b, c, model(a, b, c), $sformatf("rnd%0d", i), 0);
        end

        // Backpressure: result held 10 cycles with a competing in_valid.
        e.d = 8'd128; e.e = 1'b0; e.lat = 5;
        run(10'd0, 10'd256, 10'd0, e, "bp", 10);

        // Reset during DIV cycle 7: the in-flight result must vanish.
        @(negedge clk);
        mem_min = 10'd100; mem_mid = 10'd100; mem_max = 10'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rstdiv_out_valid", out_valid, 0);
        check("rstdiv_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("rstdiv_no_emit", seen, 0);
        e.d = 8'd128; e.e = 1'b0; e.lat = 5;
        run(10'd0, 10'd256, 10'd0, e, "post_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
